// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared types for the fetch/decode decoupling queue.
//   addr_t         : program-counter / target address
//   instr_t        : raw 32-bit instruction word
//   fetch_entry_t  : one buffered fetch result handed to decode
//   ENTRY_W        : flattened width of fetch_entry_t, used for port sizing
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [31:0]     instr_t;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
    logic   pred_taken;
    addr_t  pred_target;
    logic   fetch_exc;    // instruction access fault seen during fetch
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Decoupling FIFO between instruction fetch and decode. Holds fetched words
// with their PC and branch prediction so that either side can stall without
// stalling the other. A flush squashes every buffered entry.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous, active-high reset
//   flush_i      squash all entries (highest priority)
//   enq_valid_i  fetch presents an entry
//   enq_ready_o  queue can accept an entry (depends on occupancy only)
//   enq_entry_i  entry being presented (fetch_entry_t, flattened)
//   deq_valid_o  head entry valid for decode
//   deq_ready_i  decode consumes the head this cycle
//   deq_entry_o  head entry, read straight from storage
//   count_o      current occupancy
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               enq_valid_i,
  output logic               enq_ready_o,
  input  logic [ENTRY_W-1:0] enq_entry_i,
  output logic               deq_valid_o,
  input  logic               deq_ready_i,
  output logic [ENTRY_W-1:0] deq_entry_o,
  output logic [CNT_W-1:0]   count_o
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             enq_fire;
  logic             deq_fire;

  // Ready/valid come only from the occupancy register, so there is no
  // combinational path from deq_ready_i back to fetch.
  assign enq_ready_o = (count_q < FULL_CNT);
  assign deq_valid_o = (count_q != '0);
  assign deq_entry_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  // A flush discards whatever handshakes happen in the same cycle.
  assign enq_fire = enq_valid_i && enq_ready_o && !flush_i;
  assign deq_fire = deq_valid_o && deq_ready_i && !flush_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);   // wraps DEPTH-1 -> 0
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is reset as well so deq_entry_o never shows X after
  // reset; this costs a reset on every storage flop, acceptable at this depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq_fire) begin
      mem_q[wr_ptr_q] <= enq_entry_i;
    end
  end

  a_count_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= FULL_CNT);
  a_no_enq_full: assert property (@(posedge clk_i) disable iff (rst_i)
    enq_fire |-> (count_q != FULL_CNT));
  a_no_deq_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    deq_fire |-> (count_q != '0));

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue (DEPTH=4). Inputs change on the falling
// edge; outputs are sampled on the falling edge before new inputs are driven.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               flush_i;
  logic               enq_valid_i;
  logic               enq_ready_o;
  logic [ENTRY_W-1:0] enq_entry_i;
  logic               deq_valid_o;
  logic               deq_ready_i;
  logic [ENTRY_W-1:0] deq_entry_o;
  logic [CNT_W-1:0]   count_o;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .enq_ready_o (enq_ready_o),
    .enq_entry_i (enq_entry_i),
    .deq_valid_o (deq_valid_o),
    .deq_ready_i (deq_ready_i),
    .deq_entry_o (deq_entry_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  // Fetch-side rule: an offered entry stays put until it is accepted.
  a_enq_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (enq_valid_i && !enq_ready_o) |=> (enq_valid_i && $stable(enq_entry_i)));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Deterministic entry contents derived from the PC for directed tests.
  function automatic fetch_entry_t mk_entry(input addr_t pc);
    fetch_entry_t e;
    e.pc          = pc;
    e.instr       = pc ^ 32'hA5A5_0000;
    e.pred_taken  = pc[2];
    e.pred_target = pc + 32'h40;
    e.fetch_exc   = pc[3];
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic exp_ready,
                             input logic exp_valid, input int exp_count,
                             input fetch_entry_t exp_entry);
    check({tag, ".enq_ready"}, 128'(enq_ready_o), 128'(exp_ready));
    check({tag, ".deq_valid"}, 128'(deq_valid_o), 128'(exp_valid));
    check({tag, ".count"},     128'(count_o),     128'(exp_count));
    if (exp_valid)
      check({tag, ".deq_entry"}, 128'(deq_entry_o), 128'(exp_entry));
  endtask

  task automatic drive(input logic fl, input logic ev, input fetch_entry_t e,
                       input logic dr);
    flush_i     = fl;
    enq_valid_i = ev;
    enq_entry_i = e;
    deq_ready_i = dr;
  endtask

  // Row: expected outputs seen at this falling edge, then inputs driven.
  typedef struct {
    logic  flush;
    logic  enq_valid;
    addr_t enq_pc;
    logic  deq_ready;
    logic  exp_ready;
    logic  exp_valid;
    int    exp_count;
    addr_t exp_pc;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  fetch_entry_t mq [$];

  initial begin
    //            fl    ev    pc          dr    rdy   vld  cnt  head pc
    vecs[0]  = '{1'b0, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b0, 0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h1004, 1'b0, 1'b1, 1'b1, 1, 32'h1000};
    vecs[2]  = '{1'b0, 1'b1, 32'h1008, 1'b0, 1'b1, 1'b1, 2, 32'h1000};
    vecs[3]  = '{1'b0, 1'b1, 32'h100C, 1'b0, 1'b1, 1'b1, 3, 32'h1000};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 4, 32'h1000};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 3, 32'h1004};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 2, 32'h1008};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 1, 32'h100C};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 0, 32'h0};   // deq on empty ignored
    vecs[9]  = '{1'b0, 1'b1, 32'h2100, 1'b0, 1'b1, 1'b0, 0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h2104, 1'b0, 1'b1, 1'b1, 1, 32'h2100};
    vecs[11] = '{1'b0, 1'b1, 32'h2108, 1'b0, 1'b1, 1'b1, 2, 32'h2100};
    vecs[12] = '{1'b0, 1'b1, 32'h210C, 1'b0, 1'b1, 1'b1, 3, 32'h2100};
    vecs[13] = '{1'b0, 1'b1, 32'h2000, 1'b1, 1'b0, 1'b1, 4, 32'h2100}; // full: pop, no accept
    vecs[14] = '{1'b0, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b1, 3, 32'h2104}; // accepted now
    vecs[15] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 4, 32'h2104};
    vecs[16] = '{1'b1, 1'b1, 32'h3100, 1'b1, 1'b1, 1'b1, 3, 32'h2108}; // flush with enq+deq
    vecs[17] = '{1'b0, 1'b1, 32'h3000, 1'b0, 1'b1, 1'b0, 0, 32'h0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 1, 32'h3000};
    vecs[19] = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 0, 32'h0};

    rst_i = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // ---- directed table: fill/drain, full+deq, flush ----
    for (int i = 0; i < NV; i++) begin
      check_state($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_valid,
                  vecs[i].exp_count, mk_entry(vecs[i].exp_pc));
      drive(vecs[i].flush, vecs[i].enq_valid, mk_entry(vecs[i].enq_pc),
            vecs[i].deq_ready);
      @(negedge clk_i);
    end

    // ---- streaming: enq and deq every cycle from empty ----
    for (int i = 0; i < 100; i++) begin
      if (i == 0)
        check_state("stream0", 1'b1, 1'b0, 0, '0);
      else
        check_state($sformatf("stream%0d", i), 1'b1, 1'b1, 1,
                    mk_entry(32'h4000 + 32'(4 * (i - 1))));
      drive(1'b0, 1'b1, mk_entry(32'h4000 + 32'(4 * i)), 1'b1);
      @(negedge clk_i);
    end
    check_state("stream_last", 1'b1, 1'b1, 1, mk_entry(32'h4000 + 32'(4 * 99)));
    drive(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk_i);
    check_state("stream_empty", 1'b1, 1'b0, 0, '0);
    drive(1'b0, 1'b0, '0, 1'b0);

    // ---- asynchronous reset between edges with two entries held ----
    drive(1'b0, 1'b1, mk_entry(32'h5000), 1'b0);
    @(negedge clk_i);
    drive(1'b0, 1'b1, mk_entry(32'h5004), 1'b0);
    @(negedge clk_i);
    drive(1'b0, 1'b0, '0, 1'b0);
    check_state("pre_rst", 1'b1, 1'b1, 2, mk_entry(32'h5000));
    #2 rst_i = 1'b1;
    #1 check_state("async_rst", 1'b1, 1'b0, 0, '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_state("post_rst", 1'b1, 1'b0, 0, '0);

    // ---- random sequences against a queue model ----
    begin
      logic         hold;
      logic         ev, dr, fl, model_ready, enq_f, deq_f;
      fetch_entry_t ent;
      int           p_enq, p_deq;
      hold = 1'b0;
      ev   = 1'b0;
      ent  = '0;
      mq.delete();
      for (int s = 0; s < 10; s++) begin
        p_enq = $urandom_range(1, 3);
        p_deq = $urandom_range(1, 3);
        for (int c = 0; c < 100; c++) begin
          check_state($sformatf("rnd%0d_%0d", s, c), mq.size() < DEPTH,
                      mq.size() != 0, mq.size(),
                      (mq.size() != 0) ? mq[0] : fetch_entry_t'('0));
          fl = (c == 0);
          if (!hold) begin
            ev  = ($urandom_range(0, 3) < p_enq);
            ent = {$urandom(), $urandom(), 1'($urandom()), $urandom(), 1'($urandom())};
          end
          dr = ($urandom_range(0, 3) < p_deq);
          drive(fl, ev, ent, dr);
          model_ready = (mq.size() < DEPTH);
          enq_f = ev && model_ready && !fl;
          deq_f = dr && (mq.size() != 0) && !fl;
          if (fl) mq.delete();
          if (deq_f) void'(mq.pop_front());
          if (enq_f) mq.push_back(ent);
          hold = ev && !model_ready;
          @(negedge clk_i);
        end
      end
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_queue
